// File: rtl/cell3_vector_checker.sv
// cell3_vector_checker
// Exhaustive functional checker for a 3-input, 1-output standard cell
// (AOI21 by default). Drives all eight {A,B,C} vectors in order 0..7,
// holds each for SETTLE_CYC cycles, samples Y for one cycle and compares
// it to the TRUTH table. Reports error count, first failing vector and
// pass/fail through a start/done handshake.
//
// Ports:
//   CLK, RST            clock; asynchronous active-high reset
//   start               run request, sampled only in IDLE
//   a_o, b_o, c_o       drive to cell pins A/B/C (vec[2]/vec[1]/vec[0])
//   y_i                 cell output Y
//   busy                run in progress
//   done                one-cycle pulse at end of run
//   pass                last run had zero mismatches
//   err_count           mismatches in last run (0..8)
//   first_fail_vec      index of first mismatching vector
//   first_fail_valid    at least one mismatch in last run
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | drive 000, wait for start
// S_SETTLE | drive vec, count down scnt until the cell settles
// S_SAMPLE | drive vec, compare y_i to TRUTH[vec] at edge
// S_DONE   | one-cycle done pulse, results stable
module cell3_vector_checker #(
   parameter logic [7:0] TRUTH      = 8'h15,
   parameter int         SETTLE_CYC = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       start,
   output logic       a_o,
   output logic       b_o,
   output logic       c_o,
   input  logic       y_i,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [2:0] first_fail_vec,
   output logic       first_fail_valid
);

   localparam logic [3:0] SCNT_RELOAD = 4'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] vec_q, vec_d;
   logic [3:0] scnt_q, scnt_d;
   logic [3:0] err_q, err_d;
   logic [2:0] ffv_q, ffv_d;
   logic       ffvalid_q, ffvalid_d;
   logic       pass_q, pass_d;
   logic       mismatch;
   logic       drive_en;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= S_IDLE;
         vec_q     <= 3'd0;
         scnt_q    <= 4'd0;
         err_q     <= 4'd0;
         ffv_q     <= 3'd0;
         ffvalid_q <= 1'b0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         vec_q     <= vec_d;
         scnt_q    <= scnt_d;
         err_q     <= err_d;
         ffv_q     <= ffv_d;
         ffvalid_q <= ffvalid_d;
         pass_q    <= pass_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      scnt_d    = scnt_q;
      err_d     = err_q;
      ffv_d     = ffv_q;
      ffvalid_d = ffvalid_q;
      pass_d    = pass_q;
      mismatch  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_SETTLE;
               vec_d     = 3'd0;
               scnt_d    = SCNT_RELOAD;
               err_d     = 4'd0;
               ffv_d     = 3'd0;
               ffvalid_d = 1'b0;
               pass_d    = 1'b0;
            end
         end
         S_SETTLE: begin
            if (scnt_q == 4'd0) begin
               state_d = S_SAMPLE;
            end else begin
               scnt_d = scnt_q - 4'd1;
            end
         end
         S_SAMPLE: begin
            mismatch = (y_i != TRUTH[vec_q]);
            if (mismatch) begin
               err_d = err_q + 4'd1;
               if (!ffvalid_q) begin
                  ffv_d     = vec_q;
                  ffvalid_d = 1'b1;
               end
            end
            if (vec_q == 3'd7) begin
               state_d = S_DONE;
               // Registered on entry to DONE so pass is already valid
               // while done is high; err_d includes the final sample.
               pass_d  = (err_d == 4'd0);
            end else begin
               vec_d   = vec_q + 3'd1;
               scnt_d  = SCNT_RELOAD;
               state_d = S_SETTLE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign drive_en         = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
   assign {a_o, b_o, c_o}  = drive_en ? vec_q : 3'b000;
   assign busy             = drive_en;
   assign done             = (state_q == S_DONE);
   assign pass             = pass_q;
   assign err_count        = err_q;
   assign first_fail_vec   = ffv_q;
   assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_cell3_vector_checker.sv
// Testbench for cell3_vector_checker. Two instances: dut0 uses the default
// AOI21 table with SETTLE_CYC=2, dut1 uses a NAND3 table with SETTLE_CYC=1.
// A behavioural cell model drives y_i; a cycle model predicts busy/done/drive
// and a scoreboard queue holds expected run results until done.
module tb_cell3_vector_checker;

   typedef struct {
      int err;
      int ffv;
      int ffvalid;
      int pass;
   } res_t;

   localparam int         SET [2] = '{2, 1};
   localparam logic [7:0] TR  [2] = '{8'h15, 8'h7F};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start0 = 1'b0, start1 = 1'b0;
   logic a0, b0, c0, y0, busy0, done0, pass0, ffvalid0;
   logic a1, b1, c1, y1, busy1, done1, pass1, ffvalid1;
   logic [3:0] err0, err1;
   logic [2:0] ffv0, ffv1;

   int   mode [2] = '{0, 0};
   int   cnt  [2] = '{0, 0};
   res_t last [2];
   res_t sb0 [$];
   res_t sb1 [$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // mode: 0 good AOI21, 1 Y stuck at 1, 2 Y stuck at 0, 3 NAND3
   function automatic logic cell_y(input int m, input logic [2:0] v);
      case (m)
         0:       return ~((v[2] & v[1]) | v[0]);
         1:       return 1'b1;
         2:       return 1'b0;
         default: return ~(v[2] & v[1] & v[0]);
      endcase
   endfunction

   assign y0 = cell_y(mode[0], {a0, b0, c0});
   assign y1 = cell_y(mode[1], {a1, b1, c1});

   cell3_vector_checker #(.TRUTH(8'h15), .SETTLE_CYC(2)) dut0 (
      .CLK(clk), .RST(rst), .start(start0),
      .a_o(a0), .b_o(b0), .c_o(c0), .y_i(y0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
      .first_fail_vec(ffv0), .first_fail_valid(ffvalid0));

   cell3_vector_checker #(.TRUTH(8'h7F), .SETTLE_CYC(1)) dut1 (
      .CLK(clk), .RST(rst), .start(start1),
      .a_o(a1), .b_o(b1), .c_o(c1), .y_i(y1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .first_fail_vec(ffv1), .first_fail_valid(ffvalid1));

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   function automatic res_t model_run(input int m, input logic [7:0] tr);
      res_t r = '{0, 0, 0, 0};
      for (int v = 0; v < 8; v++) begin
         if (cell_y(m, 3'(v)) != tr[v]) begin
            if (r.ffvalid == 0) begin
               r.ffv     = v;
               r.ffvalid = 1;
            end
            r.err++;
         end
      end
      r.pass = (r.err == 0) ? 1 : 0;
      return r;
   endfunction

   function automatic res_t get_res(input int d);
      res_t r;
      if (d == 0) r = '{int'(err0), int'(ffv0), int'(ffvalid0), int'(pass0)};
      else        r = '{int'(err1), int'(ffv1), int'(ffvalid1), int'(pass1)};
      return r;
   endfunction

   task automatic cmp_res(input string pfx, input res_t o, input res_t e);
      chk({pfx, "_err"},     o.err,     e.err);
      chk({pfx, "_ffv"},     o.ffv,     e.ffv);
      chk({pfx, "_ffvalid"}, o.ffvalid, e.ffvalid);
      chk({pfx, "_pass"},    o.pass,    e.pass);
   endtask

   // Cycle model: cnt counts down through run (8*(S+1)), DONE and IDLE.
   task automatic mon(input int d);
      int   n = 8 * (SET[d] + 1);
      int   eb, ed, ev;
      logic bz, dn, st;
      logic [2:0] drv;
      res_t e;
      bz  = (d == 0) ? busy0 : busy1;
      dn  = (d == 0) ? done0 : done1;
      st  = (d == 0) ? start0 : start1;
      drv = (d == 0) ? {a0, b0, c0} : {a1, b1, c1};
      if (rst) begin
         cnt[d] = 0;
         if (d == 0) sb0.delete(); else sb1.delete();
         chk($sformatf("d%0d_rst_busy", d), int'(bz), 0);
         chk($sformatf("d%0d_rst_done", d), int'(dn), 0);
         chk($sformatf("d%0d_rst_drive", d), int'(drv), 0);
         return;
      end
      if (cnt[d] > 0) cnt[d]--;
      eb = (cnt[d] >= 2) ? 1 : 0;
      ed = (cnt[d] == 1) ? 1 : 0;
      ev = eb ? (n + 1 - cnt[d]) / (SET[d] + 1) : 0;
      chk($sformatf("d%0d_busy", d), int'(bz), eb);
      chk($sformatf("d%0d_done", d), int'(dn), ed);
      chk($sformatf("d%0d_drive", d), int'(drv), ev);
      if (ed) begin
         if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
            chk($sformatf("d%0d_sb_empty", d), 1, 0);
         end else begin
            e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
            cmp_res($sformatf("d%0d_done", d), get_res(d), e);
            last[d] = e;
         end
      end
      if (cnt[d] == 0 && st) begin
         if (d == 0) sb0.push_back(model_run(mode[d], TR[d]));
         else        sb1.push_back(model_run(mode[d], TR[d]));
         cnt[d] = n + 2;
      end
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   task automatic set_start(input int d, input logic v);
      if (d == 0) start0 = v; else start1 = v;
   endtask

   task automatic run(input int d, input int m);
      int   k = 0;
      logic dn = 1'b0;
      mode[d] = m;
      @(posedge clk); #1;
      set_start(d, 1'b1);
      @(posedge clk); #1;
      set_start(d, 1'b0);
      while (!dn && k < 100) begin
         @(negedge clk);
         dn = (d == 0) ? done0 : done1;
         k++;
      end
      if (!dn) chk($sformatf("d%0d_timeout", d), 0, 1);
      repeat (3) @(negedge clk);
      cmp_res($sformatf("d%0d_hold", d), get_res(d), last[d]);
   endtask

   initial begin
      int dcyc [$];
      int k;
      res_t z = '{0, 0, 0, 0};

      repeat (3) @(negedge clk);
      cmp_res("rst_d0", get_res(0), z);
      cmp_res("rst_d1", get_res(1), z);
      @(posedge clk); #1;
      rst = 1'b0;

      run(0, 0);
      run(0, 1);
      run(0, 2);

      // Reset 10 cycles into a stuck-at-1 run (one error already counted).
      mode[0] = 1;
      @(posedge clk); #1;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("pre_rst_err", int'(err0), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", int'(busy0), 0);
      chk("mid_rst_drive", int'({a0, b0, c0}), 0);
      chk("mid_rst_err", int'(err0), 0);
      chk("mid_rst_ffvalid", int'(ffvalid0), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (30) @(negedge clk);
      run(0, 0);

      // start held high: back-to-back runs every 26 cycles.
      mode[0] = 0;
      @(posedge clk); #1;
      start0 = 1'b1;
      k = 0;
      while (dcyc.size() < 3 && k < 120) begin
         @(negedge clk);
         if (done0) dcyc.push_back(cyc);
         k++;
      end
      chk("hold_done_count", dcyc.size(), 3);
      if (dcyc.size() == 3) begin
         chk("hold_period1", dcyc[1] - dcyc[0], 26);
         chk("hold_period2", dcyc[2] - dcyc[1], 26);
      end
      start0 = 1'b0;
      repeat (40) @(negedge clk);

      run(1, 3);
      run(1, 0);
      run(1, 2);

      repeat (5) @(negedge clk);
      chk("sb0_drained", sb0.size(), 0);
      chk("sb1_drained", sb1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
